pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit for the MIPS fetch stage: holds the PC and selects next PC
//  from sequential increment, branch, jump, return-address stack (RAS) and exception vector.
//  Adds stall, redirect priority, misalignment detection and a circular RAS for call/return.
//  Drives instruction-memory address; pc_plus4 feeds link-register writeback.
// PARAMETERS
//  ADDR_W     32            PC / target width in bits
//  RESET_VEC  32'h0000_0000 PC value loaded on reset
//  EXC_VEC    32'h8000_0180 PC value loaded on exception
//  INCR       4             sequential increment (bytes)
//  RAS_DEPTH  4             return-address stack entries (power of 2, >=2)
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       synchronous, active-high reset
//  stall          in   1       hold PC (exception still taken)
//  exception      in   1       redirect to EXC_VEC
//  branch_taken   in   1       redirect to branch_target
//  branch_target  in   ADDR_W  branch destination
//  jump           in   1       redirect to jump_target
//  jump_target    in   ADDR_W  jump destination
//  call           in   1       qualifies jump: push pc_out+INCR onto RAS
//  ret            in   1       redirect to RAS top and pop
//  pc_out         out  ADDR_W  current PC (registered)
//  pc_plus4       out  ADDR_W  pc_out+INCR (combinational, mod 2^ADDR_W)
//  misaligned     out  1       registered pulse: last loaded redirect target had addr[1:0]!=0
//  ras_empty      out  1       RAS holds 0 entries
//  ras_full       out  1       RAS holds RAS_DEPTH entries
//  ras_underflow  out  1       registered pulse: ret accepted while RAS empty
// BEHAVIOUR
//  - Reset (sync, dominates all): pc_out=RESET_VEC, RAS count=0, misaligned=0, ras_underflow=0.
//  - One register stage: inputs sampled at edge N -> pc_out updated at edge N; no other latency.
//  - Next-PC priority: exception > branch_taken > ret > jump > sequential (pc_out+INCR).
//  - stall=1 and exception=0: pc_out, RAS, flags hold; branch/jump/call/ret ignored (source re-presents).
//  - stall=1 and exception=1: exception taken; RAS untouched.
//  - Arithmetic modulo 2^ADDR_W: pc_out=max-INCR+1..max wraps to low addresses, no flag.
//  - Misalignment: redirect target with [1:0]!=0 is loaded with [1:0] forced to 0, misaligned=1
//    for one cycle; EXC_VEC/RESET_VEC never flag.
//  - RAS push: only when jump&call accepted (not overridden by exception/branch/ret):
//    push pc_out+INCR; when full, oldest entry overwritten (circular), count stays RAS_DEPTH.
//  - RAS pop: ret accepted (no exception/branch): target=top, count-1.
//    Empty: no redirect, sequential PC, count stays 0, ras_underflow=1 for one cycle.
//  - ret and jump&call together: ret wins redirect; pop then push pc_out+INCR (top replaced, count same).
//  - Exception/branch same cycle as call/ret: RAS unchanged.
//  - ras_empty/ras_full are combinational from count; reflect state after the last edge.
//  - Reset mid-call/ret sequence: RAS cleared, pending ops discarded.
// STRUCTURE
//  - Package mips_pc_pkg: default RESET_VEC/EXC_VEC/INCR constants, enum next_sel_t
//    {SEL_SEQ, SEL_BR, SEL_RET, SEL_JMP, SEL_EXC}, addr_t typedef.
//  - Sub-module pc_ras: circular stack (top pointer, count, push/pop/replace, full/empty).
//  - Top: priority encoder -> next_sel_t, next-PC mux, alignment mask, PC/flag registers.
// TESTING
//  - Reset: reset=1 one edge -> pc_out=0x0, ras_empty=1; release, 3 idle edges -> 0x4,0x8,0xC.
//  - Stall: pc_out=0x10, stall=1 + branch_taken(0x200) for 2 edges -> stays 0x10; exception+stall -> 0x80000180.
//  - Priority: exception+branch+jump same edge -> 0x80000180; branch(0x40)+jump(0x80) -> 0x40.
//  - RAS: call jumps 0x100 @pc 0x0,0x200 @pc 0x104,0x300 @pc 0x204; 3 rets -> 0x208,0x108,0x4; 4th ret -> seq, ras_underflow=1.
//  - Overflow: 5 calls (RAS_DEPTH=4) -> ras_full=1; 4 rets return newest 4 addresses; ras_empty=1 after.
//  - Wrap/misalign: pc_out=0xFFFFFFFC -> next 0x0; jump_target=0x103 -> pc_out=0x100, misaligned pulse 1 cycle.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg: shared constants, address type and next-PC source selector for the PC sequencer.
package mips_pc_pkg;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC = 32'h8000_0180;
  localparam int DEF_INCR = 4;
  localparam int DEF_RAS_DEPTH = 4;
  typedef logic [31:0] addr_t;
  typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_RET, SEL_JMP, SEL_EXC} next_sel_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] top_q, top_d, wr_ptr;
  logic [PW:0] cnt_q, cnt_d;
  logic pop_ok;
  // pop+push together rewrites the current top in place
  always_comb begin
    pop_ok = pop_i && !empty_o;
    wr_ptr = pop_ok ? top_q : top_q + PW'(1);
    top_d = (push_i == pop_ok) ? top_q : push_i ? top_q + PW'(1) : top_q - PW'(1);
    cnt_d = (push_i == pop_ok) ? cnt_q : push_i ? (full_o ? cnt_q : cnt_q + 1'b1) : cnt_q - 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[wr_ptr] <= data_i;
  end
  assign top_o = mem_q[top_q];
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (PW+1)'(DEPTH);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS fetch program counter with prioritised redirects, stall, alignment masking and RAS.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int    ADDR_W = 32,
  parameter addr_t RESET_VEC = DEF_RESET_VEC,
  parameter addr_t EXC_VEC = DEF_EXC_VEC,
  parameter int    INCR = DEF_INCR,
  parameter int    RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              stall_i,
  input  logic              exception_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              misaligned_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_underflow_o
);
  next_sel_t sel;
  logic adv, push, pop, redir;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt, ras_top;
  logic mis_q, mis_d, und_q, und_d;
  pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk_i  (clock_i),
    .rst_i  (reset_i),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_plus4_o),
    .top_o  (ras_top),
    .empty_o(ras_empty_o),
    .full_o (ras_full_o)
  );
  assign pc_plus4_o = pc_q + ADDR_W'(INCR);
  // a ret on an empty stack falls back to sequential and does not let a jump through
  always_comb begin
    sel = exception_i ? SEL_EXC : branch_taken_i ? SEL_BR :
          ret_i ? (ras_empty_o ? SEL_SEQ : SEL_RET) : jump_i ? SEL_JMP : SEL_SEQ;
    adv = !stall_i || exception_i;
    pop = adv && sel == SEL_RET;
    push = adv && jump_i && call_i && (sel == SEL_JMP || sel == SEL_RET);
    tgt = sel == SEL_BR ? branch_target_i : sel == SEL_RET ? ras_top : jump_target_i;
    redir = sel == SEL_BR || sel == SEL_RET || sel == SEL_JMP;
    pc_d = sel == SEL_EXC ? ADDR_W'(EXC_VEC) : redir ? {tgt[ADDR_W-1:2], 2'b00} : pc_plus4_o;
    mis_d = redir && tgt[1:0] != 2'b00;
    und_d = ret_i && ras_empty_o && !exception_i && !branch_taken_i;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q <= ADDR_W'(RESET_VEC);
      mis_q <= 1'b0;
      und_q <= 1'b0;
    end else if (adv) begin
      pc_q <= pc_d;
      mis_q <= mis_d;
      und_q <= und_d;
    end
  end
  assign pc_out_o = pc_q;
  assign misaligned_o = mis_q;
  assign ras_underflow_o = und_q;
endmodule
